// File: rtl/arbitro_escritura_registros.sv
// Register-file write-port arbiter: four sources (result, immediate, bus, stack) compete for
// one write port through a fixed IDLE -> SELECCION -> ESCRITURA sequence with registered outputs.
module arbitro_escritura_registros #(
  parameter int          REG_ADDR_W     = 3,
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic [3:0]            i_Req,
  input  logic [REG_ADDR_W-1:0] i_Dir_Resultado,
  input  logic [REG_ADDR_W-1:0] i_Dir_Inmediato,
  input  logic [REG_ADDR_W-1:0] i_Dir_Bus,
  input  logic [REG_ADDR_W-1:0] i_Dir_Stack,
  input  logic                  i_Stall,
  output logic [1:0]            o_Selector,
  output logic                  o_Reg_We,
  output logic [REG_ADDR_W-1:0] o_Reg_Addr,
  output logic [3:0]            o_Ack,
  output logic                  o_Ocupado
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SELECCION = 2'd1,
    ESCRITURA = 2'd2
  } estado_t;

  estado_t               estado_q, estado_d;
  logic [1:0]            sel_q, sel_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            ack_q, ack_d;
  logic                  ocupado_q, ocupado_d;

  logic [1:0]            ganador;
  logic [1:0]            candidato;
  logic                  encontrado;
  logic [REG_ADDR_W-1:0] dir_ganador;

  // sel_q doubles as the winner register for the whole sequence.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      estado_q  <= IDLE;
      sel_q     <= 2'd0;
      ptr_q     <= 2'd0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      ack_q     <= 4'b0000;
      ocupado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      ack_q     <= ack_d;
      ocupado_q <= ocupado_d;
    end
  end

  // Scan starts at the round-robin pointer, or at channel 0 in fixed-priority mode.
  always_comb begin
    ganador    = 2'd0;
    candidato  = 2'd0;
    encontrado = 1'b0;
    for (int i = 0; i < 4; i++) begin
      candidato = (FIXED_PRIORITY != 0) ? 2'(i) : ptr_q + 2'(i);
      if (!encontrado && i_Req[candidato]) begin
        ganador    = candidato;
        encontrado = 1'b1;
      end
    end
  end

  always_comb begin
    dir_ganador = i_Dir_Resultado;
    case (ganador)
      2'd0:    dir_ganador = i_Dir_Resultado;
      2'd1:    dir_ganador = i_Dir_Inmediato;
      2'd2:    dir_ganador = i_Dir_Bus;
      default: dir_ganador = i_Dir_Stack;
    endcase
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      IDLE: begin
        if (i_Req != 4'b0000) estado_d = SELECCION;
      end
      SELECCION: begin
        if (!i_Req[sel_q])  estado_d = IDLE;
        else if (!i_Stall)  estado_d = ESCRITURA;
      end
      ESCRITURA: estado_d = IDLE;
      default:   estado_d = IDLE;
    endcase
  end

  // Selector and address hold their last values outside a grant.
  always_comb begin
    sel_d     = sel_q;
    addr_d    = addr_q;
    ptr_d     = ptr_q;
    we_d      = 1'b0;
    ack_d     = 4'b0000;
    ocupado_d = 1'b0;
    case (estado_q)
      IDLE: begin
        if (i_Req != 4'b0000) begin
          sel_d     = ganador;
          addr_d    = dir_ganador;
          ocupado_d = 1'b1;
        end
      end
      SELECCION: begin
        if (i_Req[sel_q]) begin
          ocupado_d = 1'b1;
          if (!i_Stall) begin
            we_d  = 1'b1;
            ack_d = 4'b0001 << sel_q;
          end
        end
      end
      ESCRITURA: begin
        ptr_d = sel_q + 2'd1;
      end
      default: begin
        ocupado_d = 1'b0;
      end
    endcase
  end

  assign o_Selector = sel_q;
  assign o_Reg_We   = we_q;
  assign o_Reg_Addr = addr_q;
  assign o_Ack      = ack_q;
  assign o_Ocupado  = ocupado_q;

endmodule
